multicycle_ctrl: RTL and testbench

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

---
 rtl/multicycle_ctrl_pkg.sv | 95 +++++++++
 rtl/mc_decode.sv | 105 ++++++++++
 rtl/multicycle_ctrl.sv | 169 ++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/multicycle_ctrl_pkg.sv
// multicycle_ctrl_pkg
// Shared definitions for the multicycle MIPS-subset controller:
//   - FSM state encoding (visible on the controller's state output)
//   - opcode / funct constants for the supported instruction set
//   - encodings of the pc_src, alu_op, ext_op, reg_dst and mem2reg fields
//   - the instruction-class one-hot and static-field bundles that the
//     decoder hands to the FSM
package multicycle_ctrl_pkg;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    // Primary opcodes, IR[31:26]
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BGTZ  = 6'h07;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LB    = 6'h20;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // R-type function codes, IR[5:0]
    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_JR   = 6'h08;
    localparam logic [5:0] FN_JALR = 6'h09;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_XOR  = 6'h26;

    // Next-PC source select
    localparam logic [2:0] PC_PLUS4  = 3'b000;
    localparam logic [2:0] PC_BRANCH = 3'b001;
    localparam logic [2:0] PC_JUMP   = 3'b010;
    localparam logic [2:0] PC_REG    = 3'b100;

    // ALU operation select
    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_XOR = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLL = 3'b100;

    // Immediate extension mode
    localparam logic [2:0] EXT_ZERO = 3'b000;
    localparam logic [2:0] EXT_SIGN = 3'b001;
    localparam logic [2:0] EXT_LUI  = 3'b010;

    // Destination register select
    localparam logic [1:0] RD_RT = 2'b00;
    localparam logic [1:0] RD_RD = 2'b01;
    localparam logic [1:0] RD_RA = 2'b10;

    // Register-file write-data select
    localparam logic [2:0] M2R_ALU = 3'b000;
    localparam logic [2:0] M2R_MEM = 3'b001;
    localparam logic [2:0] M2R_LUI = 3'b010;
    localparam logic [2:0] M2R_PC  = 3'b011;

    // Exactly one bit is set for a legal instruction, none for an illegal one.
    // jump = j, link = jal, jumpReg = jr, linkReg = jalr.
    typedef struct packed {
        logic alu;
        logic load;
        logic store;
        logic branch;
        logic jump;
        logic link;
        logic jumpReg;
        logic linkReg;
    } instrClass_t;

    typedef struct packed {
        logic [2:0] aluOp;
        logic       aluSrc;
        logic [2:0] extOp;
        logic [1:0] regDst;
        logic [2:0] mem2reg;
    } ctrlFields_t;

    // Loads and stores both take the MEM state after EXEC
    function automatic logic isMemClass(input instrClass_t c);
        return c.load | c.store;
    endfunction

endpackage

// File: rtl/mc_decode.sv
// mc_decode
// Purely combinational instruction decoder for the multicycle controller.
// Ports:
//   i_opcode  [5:0]  IR[31:26]
//   i_funct   [5:0]  IR[5:0], only meaningful for R-type
//   o_class          instruction-class one-hot (all zero when illegal)
//   o_fields         static datapath fields (alu_op, alu_src, ext_op,
//                    reg_dst, mem2reg); all zero when illegal
//   o_legal          1 when opcode/funct is in the supported set
module mc_decode
    import multicycle_ctrl_pkg::*;
(
    input  logic [5:0]  i_opcode,
    input  logic [5:0]  i_funct,
    output instrClass_t o_class,
    output ctrlFields_t o_fields,
    output logic        o_legal
);

    // Every output starts from the all-zero encoding so that an unsupported
    // opcode/funct pair leaves nothing but o_legal=0 behind.
    always_comb begin
        o_class          = '0;
        o_fields.aluOp   = ALU_ADD;
        o_fields.aluSrc  = 1'b0;
        o_fields.extOp   = EXT_ZERO;
        o_fields.regDst  = RD_RT;
        o_fields.mem2reg = M2R_ALU;
        o_legal          = 1'b1;

        case (i_opcode)
            OP_RTYPE: begin
                o_fields.regDst = RD_RD;
                case (i_funct)
                    FN_ADD: o_class.alu = 1'b1;
                    FN_SUB: begin
                        o_class.alu    = 1'b1;
                        o_fields.aluOp = ALU_SUB;
                    end
                    FN_XOR: begin
                        o_class.alu    = 1'b1;
                        o_fields.aluOp = ALU_XOR;
                    end
                    FN_SLL: begin
                        o_class.alu    = 1'b1;
                        o_fields.aluOp = ALU_SLL;
                    end
                    FN_JR: begin
                        o_class.jumpReg = 1'b1;
                        o_fields.regDst = RD_RT;
                    end
                    FN_JALR: begin
                        o_class.linkReg  = 1'b1;
                        o_fields.mem2reg = M2R_PC;
                    end
                    default: begin
                        o_legal         = 1'b0;
                        o_fields.regDst = RD_RT;
                    end
                endcase
            end
            OP_ORI: begin
                o_class.alu     = 1'b1;
                o_fields.aluOp  = ALU_OR;
                o_fields.aluSrc = 1'b1;
                o_fields.extOp  = EXT_ZERO;
            end
            OP_ADDI: begin
                o_class.alu     = 1'b1;
                o_fields.aluSrc = 1'b1;
                o_fields.extOp  = EXT_SIGN;
            end
            OP_LUI: begin
                o_class.alu      = 1'b1;
                o_fields.aluSrc  = 1'b1;
                o_fields.extOp   = EXT_LUI;
                o_fields.mem2reg = M2R_LUI;
            end
            OP_LW, OP_LB: begin
                o_class.load     = 1'b1;
                o_fields.aluSrc  = 1'b1;
                o_fields.extOp   = EXT_SIGN;
                o_fields.mem2reg = M2R_MEM;
            end
            OP_SW: begin
                o_class.store   = 1'b1;
                o_fields.aluSrc = 1'b1;
                o_fields.extOp  = EXT_SIGN;
            end
            OP_BEQ, OP_BGTZ: begin
                o_class.branch = 1'b1;
                o_fields.aluOp = ALU_SUB;
                o_fields.extOp = EXT_SIGN;
            end
            OP_J: o_class.jump = 1'b1;
            OP_JAL: begin
                o_class.link     = 1'b1;
                o_fields.regDst  = RD_RA;
                o_fields.mem2reg = M2R_PC;
            end
            default: o_legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl
// FSM controller for a multicycle MIPS-subset datapath
// (FETCH -> DECODE -> EXEC -> [MEM] -> [WB], HALT on an illegal instruction).
// Ports:
//   clk, reset (async, active low)
//   opcode, funct        instruction fields, stable from DECODE onward
//   mem_ready            memory access completes this cycle
//   branch_taken         comparator result for beq/bgtz
//   mem_req, mem_we, ir_we, pc_we, rf_we   strobes
//   pc_src, alu_op, alu_src, ext_op, reg_dst, mem2reg   encoded controls
//   state                current FSM state
//   illegal              sticky halt flag
//   instr_cnt            retired-instruction count (wraps)
module multicycle_ctrl
    import multicycle_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [5:0]  opcode,
    input  logic [5:0]  funct,
    input  logic        mem_ready,
    input  logic        branch_taken,
    output logic        mem_req,
    output logic        mem_we,
    output logic        ir_we,
    output logic        pc_we,
    output logic        rf_we,
    output logic [2:0]  pc_src,
    output logic [2:0]  alu_op,
    output logic        alu_src,
    output logic [2:0]  ext_op,
    output logic [1:0]  reg_dst,
    output logic [2:0]  mem2reg,
    output logic [2:0]  state,
    output logic        illegal,
    output logic [31:0] instr_cnt
);

    state_t      r_state;
    state_t      w_nextState;
    logic        r_active;
    logic [31:0] r_instrCnt;
    logic        w_retire;
    logic        w_fieldsEn;
    instrClass_t w_class;
    ctrlFields_t w_fields;
    logic        w_legal;

    mc_decode u_decode (
        .i_opcode (opcode),
        .i_funct  (funct),
        .o_class  (w_class),
        .o_fields (w_fields),
        .o_legal  (w_legal)
    );

    // State register. r_active stays low until the first rising edge after
    // reset is released, so nothing is requested from memory and the FSM
    // cannot move on a partially-released reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= S_FETCH;
            r_active <= 1'b0;
        end else begin
            r_active <= 1'b1;
            if (r_active) begin
                r_state <= w_nextState;
            end
        end
    end

    // Retired-instruction counter, bumped as an instruction leaves its last
    // state; it simply wraps at the top of its range.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_instrCnt <= 32'd0;
        end else if (r_active && w_retire) begin
            r_instrCnt <= r_instrCnt + 32'd1;
        end
    end

    // Next-state and strobe logic. Strobes are zero by default, which also
    // covers reset (r_active cleared asynchronously) and HALT.
    always_comb begin
        w_nextState = r_state;
        w_retire    = 1'b0;
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        ir_we       = 1'b0;
        pc_we       = 1'b0;
        rf_we       = 1'b0;
        pc_src      = PC_PLUS4;

        if (r_active) begin
            case (r_state)
                S_FETCH: begin
                    mem_req = 1'b1;
                    if (mem_ready) begin
                        ir_we       = 1'b1;
                        pc_we       = 1'b1;
                        pc_src      = PC_PLUS4;
                        w_nextState = S_DECODE;
                    end
                end
                S_DECODE: begin
                    w_nextState = w_legal ? S_EXEC : S_HALT;
                end
                S_EXEC: begin
                    if (w_class.alu) begin
                        w_nextState = S_WB;
                    end else if (isMemClass(w_class)) begin
                        w_nextState = S_MEM;
                    end else begin
                        w_nextState = S_FETCH;
                        w_retire    = 1'b1;
                        if (w_class.branch) begin
                            pc_src = PC_BRANCH;
                            pc_we  = branch_taken;
                        end else if (w_class.jump || w_class.link) begin
                            pc_src = PC_JUMP;
                            pc_we  = 1'b1;
                            rf_we  = w_class.link;
                        end else if (w_class.jumpReg || w_class.linkReg) begin
                            pc_src = PC_REG;
                            pc_we  = 1'b1;
                            rf_we  = w_class.linkReg;
                        end else begin
                            // Unreachable for a decoded-legal instruction
                            w_nextState = S_HALT;
                            w_retire    = 1'b0;
                        end
                    end
                end
                S_MEM: begin
                    mem_req = 1'b1;
                    mem_we  = w_class.store;
                    if (mem_ready) begin
                        w_nextState = w_class.store ? S_FETCH : S_WB;
                        w_retire    = w_class.store;
                    end
                end
                S_WB: begin
                    rf_we       = 1'b1;
                    w_nextState = S_FETCH;
                    w_retire    = 1'b1;
                end
                S_HALT: begin
                    w_nextState = S_HALT;
                end
                default: begin
                    w_nextState = S_HALT;
                end
            endcase
        end
    end

    // Static fields only mean something once the instruction is in the IR
    assign w_fieldsEn = (r_state != S_FETCH) && (r_state != S_HALT);
    assign alu_op     = w_fieldsEn ? w_fields.aluOp   : 3'b000;
    assign alu_src    = w_fieldsEn ? w_fields.aluSrc  : 1'b0;
    assign ext_op     = w_fieldsEn ? w_fields.extOp   : 3'b000;
    assign reg_dst    = w_fieldsEn ? w_fields.regDst  : 2'b00;
    assign mem2reg    = w_fieldsEn ? w_fields.mem2reg : 3'b000;

    assign state     = r_state;
    assign illegal   = (r_state == S_HALT);
    assign instr_cnt = r_instrCnt;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl
// Scoreboard bench for multicycle_ctrl. The driver walks each instruction
// through its expected phase sequence (fetch/mem wait cycles included) and
// pushes one expected output record per cycle; the monitor pops a record on
// every falling edge and compares it with the DUT outputs.
module tb_multicycle_ctrl;

    localparam int K_ALU = 0, K_LOAD = 1, K_STORE = 2, K_BR = 3, K_J = 4,
                   K_JAL = 5, K_JR = 6, K_JALR = 7, K_ILL = 8;
    localparam int P_F = 0, P_D = 1, P_E = 2, P_M = 3, P_W = 4, P_H = 5;
    localparam int I_ADD = 0, I_LW = 9, I_BEQ = 12, I_JAL = 15, I_ILL = 16;
    localparam int N_INSTR = 17;

    typedef struct {
        int          idx;
        logic [2:0]  st;
        logic        memReq, memWe, irWe, pcWe, rfWe, ill;
        logic [2:0]  pcSrc, aluOp, m2r;
        logic [1:0]  regDst;
        logic [31:0] cnt;
    } exp_t;

    logic        clk, reset, mem_ready, branch_taken;
    logic [5:0]  opcode, funct;
    logic        mem_req, mem_we, ir_we, pc_we, rf_we, alu_src, illegal;
    logic [2:0]  pc_src, alu_op, ext_op, mem2reg, state;
    logic [1:0]  reg_dst;
    logic [31:0] instr_cnt;

    string       nm[N_INSTR];
    logic [5:0]  opcT[N_INSTR], fnT[N_INSTR];
    int          kindT[N_INSTR];
    logic [2:0]  aluOpT[N_INSTR], m2rT[N_INSTR];
    logic [1:0]  rdT[N_INSTR];

    exp_t        sb[$];
    logic [31:0] modelCnt;
    int          checks, errors;

    multicycle_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .opcode       (opcode),
        .funct        (funct),
        .mem_ready    (mem_ready),
        .branch_taken (branch_taken),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .ir_we        (ir_we),
        .pc_we        (pc_we),
        .rf_we        (rf_we),
        .pc_src       (pc_src),
        .alu_op       (alu_op),
        .alu_src      (alu_src),
        .ext_op       (ext_op),
        .reg_dst      (reg_dst),
        .mem2reg      (mem2reg),
        .state        (state),
        .illegal      (illegal),
        .instr_cnt    (instr_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic setInstr(input int i, input string n, input logic [5:0] op,
                            input logic [5:0] fn, input int k, input logic [2:0] a,
                            input logic [1:0] r, input logic [2:0] m);
        nm[i] = n; opcT[i] = op; fnT[i] = fn; kindT[i] = k;
        aluOpT[i] = a; rdT[i] = r; m2rT[i] = m;
    endtask

    // Instruction set: opcode, funct, class, and the alu_op/reg_dst/mem2reg
    // values each instruction needs from its MIPS semantics
    task automatic fillTable();
        setInstr(0,  "add",  6'h00, 6'h20, K_ALU,   3'd0, 2'd1, 3'd0);
        setInstr(1,  "sub",  6'h00, 6'h22, K_ALU,   3'd1, 2'd1, 3'd0);
        setInstr(2,  "xor",  6'h00, 6'h26, K_ALU,   3'd2, 2'd1, 3'd0);
        setInstr(3,  "sll",  6'h00, 6'h00, K_ALU,   3'd4, 2'd1, 3'd0);
        setInstr(4,  "jr",   6'h00, 6'h08, K_JR,    3'd0, 2'd0, 3'd0);
        setInstr(5,  "jalr", 6'h00, 6'h09, K_JALR,  3'd0, 2'd1, 3'd3);
        setInstr(6,  "ori",  6'h0D, 6'h00, K_ALU,   3'd3, 2'd0, 3'd0);
        setInstr(7,  "addi", 6'h08, 6'h00, K_ALU,   3'd0, 2'd0, 3'd0);
        setInstr(8,  "lui",  6'h0F, 6'h00, K_ALU,   3'd0, 2'd0, 3'd2);
        setInstr(9,  "lw",   6'h23, 6'h00, K_LOAD,  3'd0, 2'd0, 3'd1);
        setInstr(10, "lb",   6'h20, 6'h00, K_LOAD,  3'd0, 2'd0, 3'd1);
        setInstr(11, "sw",   6'h2B, 6'h00, K_STORE, 3'd0, 2'd0, 3'd0);
        setInstr(12, "beq",  6'h04, 6'h00, K_BR,    3'd1, 2'd0, 3'd0);
        setInstr(13, "bgtz", 6'h07, 6'h00, K_BR,    3'd1, 2'd0, 3'd0);
        setInstr(14, "j",    6'h02, 6'h00, K_J,     3'd0, 2'd0, 3'd0);
        setInstr(15, "jal",  6'h03, 6'h00, K_JAL,   3'd0, 2'd2, 3'd3);
        setInstr(16, "ill",  6'h3F, 6'h00, K_ILL,   3'd0, 2'd0, 3'd0);
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic rb();
        return 1'($urandom);
    endfunction

    // Reference model: what the outputs must be in a given phase of a given
    // instruction, with the cycle's mem_ready and branch_taken
    function automatic exp_t expectFor(input int ph, input int i, input logic rdy,
                                       input logic tk);
        exp_t e;
        e.idx = i; e.st = 3'(ph); e.cnt = modelCnt; e.ill = (ph == P_H);
        e.memReq = 1'b0; e.memWe = 1'b0; e.irWe = 1'b0; e.pcWe = 1'b0; e.rfWe = 1'b0;
        e.pcSrc = 3'd0; e.aluOp = 3'd0; e.regDst = 2'd0; e.m2r = 3'd0;
        if (ph != P_F && ph != P_H) begin
            e.aluOp = aluOpT[i]; e.regDst = rdT[i]; e.m2r = m2rT[i];
        end
        case (ph)
            P_F: begin e.memReq = 1'b1; e.irWe = rdy; e.pcWe = rdy; end
            P_E: case (kindT[i])
                K_BR:   begin e.pcSrc = 3'b001; e.pcWe = tk; end
                K_J:    begin e.pcSrc = 3'b010; e.pcWe = 1'b1; end
                K_JAL:  begin e.pcSrc = 3'b010; e.pcWe = 1'b1; e.rfWe = 1'b1; end
                K_JR:   begin e.pcSrc = 3'b100; e.pcWe = 1'b1; end
                K_JALR: begin e.pcSrc = 3'b100; e.pcWe = 1'b1; e.rfWe = 1'b1; end
                default: ;
            endcase
            P_M: begin e.memReq = 1'b1; e.memWe = (kindT[i] == K_STORE); end
            P_W: e.rfWe = 1'b1;
            default: ;
        endcase
        return e;
    endfunction

    task automatic cycle(input int ph, input int i, input logic rdy, input logic tk,
                         input logic [5:0] op, input logic [5:0] fn);
        @(posedge clk);
        #1;
        opcode = op; funct = fn; mem_ready = rdy; branch_taken = tk;
        sb.push_back(expectFor(ph, i, rdy, tk));
    endtask

    // One instruction end to end. takenSel<0 randomises branch_taken in EXEC;
    // abortMem leaves the instruction stalled in MEM for memWait cycles.
    task automatic applyStimulus(input int i, input int fetchWait, input int memWait,
                                 input int takenSel, input bit abortMem);
        logic [5:0] op, fn;
        logic tk;
        op = opcT[i];
        fn = (op == 6'h00) ? fnT[i] : 6'($urandom);
        for (int w = 0; w <= fetchWait; w++) cycle(P_F, i, (w == fetchWait), rb(), op, fn);
        cycle(P_D, i, rb(), rb(), op, fn);
        if (kindT[i] == K_ILL) begin
            for (int h = 0; h < 10; h++) cycle(P_H, i, rb(), rb(), op, fn);
            return;
        end
        tk = (takenSel < 0) ? rb() : (takenSel != 0);
        cycle(P_E, i, rb(), tk, op, fn);
        if (kindT[i] == K_LOAD || kindT[i] == K_STORE) begin
            if (abortMem) begin
                for (int w = 0; w < memWait; w++) cycle(P_M, i, 1'b0, rb(), op, fn);
                return;
            end
            for (int w = 0; w <= memWait; w++) cycle(P_M, i, (w == memWait), rb(), op, fn);
        end
        if (kindT[i] == K_ALU || kindT[i] == K_LOAD) cycle(P_W, i, rb(), rb(), op, fn);
        modelCnt++;
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "/state"},     32'(state),     32'd0);
        checkOutput({tag, "/mem_req"},   32'(mem_req),   32'd0);
        checkOutput({tag, "/mem_we"},    32'(mem_we),    32'd0);
        checkOutput({tag, "/ir_we"},     32'(ir_we),     32'd0);
        checkOutput({tag, "/pc_we"},     32'(pc_we),     32'd0);
        checkOutput({tag, "/rf_we"},     32'(rf_we),     32'd0);
        checkOutput({tag, "/pc_src"},    32'(pc_src),    32'd0);
        checkOutput({tag, "/alu_op"},    32'(alu_op),    32'd0);
        checkOutput({tag, "/alu_src"},   32'(alu_src),   32'd0);
        checkOutput({tag, "/ext_op"},    32'(ext_op),    32'd0);
        checkOutput({tag, "/reg_dst"},   32'(reg_dst),   32'd0);
        checkOutput({tag, "/mem2reg"},   32'(mem2reg),   32'd0);
        checkOutput({tag, "/illegal"},   32'(illegal),   32'd0);
        checkOutput({tag, "/instr_cnt"}, instr_cnt,      32'd0);
    endtask

    // Assert reset between clock edges, check outputs clear at once and stay
    // clear while held, then release ahead of a rising edge
    task automatic doReset();
        @(negedge clk);
        #2;
        reset = 1'b0; mem_ready = 1'b0; branch_taken = 1'b0;
        #1;
        checkResetOutputs("reset_now");
        repeat (2) @(posedge clk);
        #1;
        mem_ready = 1'b1;
        checkResetOutputs("reset_held");
        @(negedge clk);
        reset = 1'b1;
        modelCnt = 32'd0;
    endtask

    // Monitor: compare every cycle the driver has described
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                checkOutput($sformatf("%s/state", nm[e.idx]),     32'(state),   32'(e.st));
                checkOutput($sformatf("%s/mem_req", nm[e.idx]),   32'(mem_req), 32'(e.memReq));
                checkOutput($sformatf("%s/mem_we", nm[e.idx]),    32'(mem_we),  32'(e.memWe));
                checkOutput($sformatf("%s/ir_we", nm[e.idx]),     32'(ir_we),   32'(e.irWe));
                checkOutput($sformatf("%s/pc_we", nm[e.idx]),     32'(pc_we),   32'(e.pcWe));
                checkOutput($sformatf("%s/rf_we", nm[e.idx]),     32'(rf_we),   32'(e.rfWe));
                checkOutput($sformatf("%s/pc_src", nm[e.idx]),    32'(pc_src),  32'(e.pcSrc));
                checkOutput($sformatf("%s/alu_op", nm[e.idx]),    32'(alu_op),  32'(e.aluOp));
                checkOutput($sformatf("%s/reg_dst", nm[e.idx]),   32'(reg_dst), 32'(e.regDst));
                checkOutput($sformatf("%s/mem2reg", nm[e.idx]),   32'(mem2reg), 32'(e.m2r));
                checkOutput($sformatf("%s/illegal", nm[e.idx]),   32'(illegal), 32'(e.ill));
                checkOutput($sformatf("%s/instr_cnt", nm[e.idx]), instr_cnt,    e.cnt);
            end
        end
    end

    initial begin
        checks = 0; errors = 0; modelCnt = 32'd0;
        fillTable();
        reset = 1'b0; mem_ready = 1'b0; branch_taken = 1'b0; opcode = 6'd0; funct = 6'd0;
        repeat (2) @(posedge clk);
        doReset();

        $display("[TB] directed: add, lw with MEM stall, beq not-taken/taken, jal");
        applyStimulus(I_ADD, 0, 0, -1, 1'b0);
        applyStimulus(I_LW, 0, 3, -1, 1'b0);
        applyStimulus(I_BEQ, 0, 0, 0, 1'b0);
        applyStimulus(I_BEQ, 0, 0, 1, 1'b0);
        applyStimulus(I_JAL, 0, 0, -1, 1'b0);

        $display("[TB] directed: illegal opcode halts until reset");
        applyStimulus(I_ILL, 0, 0, -1, 1'b0);
        doReset();

        $display("[TB] randomized instruction stream");
        for (int n = 0; n < 250; n++) begin
            applyStimulus(int'($urandom_range(0, 15)), int'($urandom_range(0, 2)),
                          int'($urandom_range(0, 3)), -1, 1'b0);
        end

        $display("[TB] directed: reset during a MEM stall");
        applyStimulus(I_LW, 1, 3, -1, 1'b1);
        doReset();
        applyStimulus(I_ADD, 0, 0, -1, 1'b0);
        applyStimulus(I_ADD, 1, 0, -1, 1'b0);

        @(negedge clk);
        #1;
        checkOutput("scoreboard/leftover", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
